// File: rtl/seq_div_16_8.sv
// Sequential unsigned restoring divider: N_W-bit dividend by D_W-bit divisor, one quotient bit
// per cycle, with valid/ready handshakes on both the operand and the result side.
module seq_div_16_8 #(
    parameter int unsigned N_W = 16,
    parameter int unsigned D_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] IN1,
    input  logic [D_W-1:0] IN2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] Quot,
    output logic [D_W-1:0] Rem,
    output logic           dz,
    output logic           ovf
);

    localparam int unsigned CntW = $clog2(N_W + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [N_W-1:0]  dvd_q, dvd_d;
    logic [D_W-1:0]  div_q, div_d;
    logic [D_W:0]    prem_q, prem_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_pend_q, ovf_pend_d;
    logic [N_W-1:0]  quot_q, quot_d;
    logic [D_W-1:0]  rem_q, rem_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;

    logic [D_W+1:0]  shifted;
    logic [D_W+1:0]  trial;
    logic            fits;
    logic            ovf_in;

    // Two extra bits: the shifted remainder can exceed 2^D_W, so the sign needs its own bit.
    assign shifted = {prem_q, dvd_q[N_W-1]};
    assign trial   = shifted - {2'b00, div_q};
    assign fits    = ~trial[D_W+1];
    // Quotient overflows D_W bits exactly when the dividend's upper part is >= divisor.
    assign ovf_in  = (IN2 != '0) && ((IN1 >> D_W) >= N_W'(IN2));

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Quot      = quot_q;
    assign Rem       = rem_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        div_d      = div_q;
        prem_d     = prem_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dvd_d = IN1;
                    div_d = IN2;
                    if (IN2 == '0) begin
                        quot_d  = '1;
                        rem_d   = IN1[D_W-1:0];
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        prem_d     = '0;
                        cnt_d      = '0;
                        ovf_pend_d = ovf_in;
                        state_d    = StBusy;
                    end
                end
            end
            StBusy: begin
                prem_d = fits ? trial[D_W:0] : shifted[D_W:0];
                dvd_d  = {dvd_q[N_W-2:0], fits};
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(N_W - 1)) begin
                    quot_d  = dvd_d;
                    rem_d   = prem_d[D_W-1:0];
                    dz_d    = 1'b0;
                    ovf_d   = ovf_pend_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dvd_q      <= '0;
            div_q      <= '0;
            prem_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            div_q      <= div_d;
            prem_q     <= prem_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_seq_div_16_8.sv
// Directed-vector bench for seq_div_16_8: table of hand-computed results, handshake corner cases,
// reset mid-operation and a bounded random/product sweep against an integer model.
module tb_seq_div_16_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] IN1;
    logic [7:0]  IN2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Quot;
    logic [7:0]  Rem;
    logic        dz;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_div_16_8 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .IN1      (IN1),
        .IN2      (IN2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Quot     (Quot),
        .Rem      (Rem),
        .dz       (dz),
        .ovf      (ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        edz;
        logic        eovf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Latency counts edges from the accepting edge inclusive: 17 normally, 1 for divide-by-zero.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                          input logic [7:0] er, input logic edz, input logic eovf,
                          input string tag);
        int lat;
        @(negedge clk);
        IN1      = a;
        IN2      = b;
        in_valid = 1'b1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), edz ? 32'd1 : 32'd17);
        chk({tag, " Quot"}, 32'(Quot), 32'(eq));
        chk({tag, " Rem"}, 32'(Rem), 32'(er));
        chk({tag, " dz"}, 32'(dz), 32'(edz));
        chk({tag, " ovf"}, 32'(ovf), 32'(eovf));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic [7:0]  pa;
        int          bad;
        int          cyc;

        vecs[0]  = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 1'b0};
        vecs[1]  = '{16'hFE01,  8'd255, 16'd255,   8'd0,    1'b0, 1'b0};
        vecs[2]  = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,    1'b0, 1'b1};
        vecs[3]  = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1, 1'b0};
        vecs[4]  = '{16'd500,   8'd3,   16'd166,   8'd2,    1'b0, 1'b0};
        vecs[5]  = '{16'hFFFF,  8'd255, 16'd257,   8'd0,    1'b0, 1'b1};
        vecs[6]  = '{16'd100,   8'd200, 16'd0,     8'd100,  1'b0, 1'b0};
        vecs[7]  = '{16'hFF00,  8'd16,  16'h0FF0,  8'd0,    1'b0, 1'b1};
        vecs[8]  = '{16'd0,     8'd5,   16'd0,     8'd0,    1'b0, 1'b0};
        vecs[9]  = '{16'd12345, 8'd123, 16'd100,   8'd45,   1'b0, 1'b0};
        vecs[10] = '{16'h00FF,  8'd0,   16'hFFFF,  8'hFF,   1'b1, 1'b0};
        vecs[11] = '{16'd255,   8'd255, 16'd1,     8'd0,    1'b0, 1'b0};
        vecs[12] = '{16'd256,   8'd1,   16'd256,   8'd0,    1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        IN1       = '0;
        IN2       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset Quot", 32'(Quot), 32'd0);
        chk("reset Rem", 32'(Rem), 32'd0);
        chk("reset flags", 32'({dz, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].edz, vecs[i].eovf,
                   $sformatf("vec%0d", i));
        end

        // Backpressure plus input noise during BUSY and DONE.
        bad = 0;
        @(negedge clk);
        IN1      = 16'd1000;
        IN2      = 8'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            IN1      = 16'($urandom);
            IN2      = 8'($urandom);
            in_valid = 1'($urandom);
            if (in_ready) bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp latency", 32'(cyc), 32'd17);
        repeat (10) begin
            @(negedge clk);
            IN1       = 16'($urandom);
            IN2       = 8'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || Quot !== 16'd142 || Rem !== 8'd6 || dz || ovf) bad++;
        end
        chk("bp stable/no accept", 32'(bad), 32'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        chk("bp held Quot", 32'(Quot), 32'd142);
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        chk("bp no extra result", 32'(bad), 32'd0);
        run_op(16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 1'b1, "bp next");

        // Reset while BUSY abandons the operation.
        @(negedge clk);
        IN1      = 16'd500;
        IN2      = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst Quot", 32'(Quot), 32'd0);
        chk("midrst Rem", 32'(Rem), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        chk("midrst no result", 32'(bad), 32'd0);
        run_op(16'd500, 8'd3, 16'd166, 8'd2, 1'b0, 1'b0, "after rst");

        // Random operand pairs against the integer model.
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            run_op(ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0, ((ra >> 8) >= 16'(rb)),
                   $sformatf("rnd %0d/%0d", ra, rb));
        end

        // Exact products a*b: quotient a, remainder 0, never overflow.
        for (int i = 0; i < 300; i++) begin
            pa = 8'($urandom);
            rb = 8'($urandom_range(1, 255));
            if (i == 0) begin
                pa = 8'd255;
                rb = 8'd1;
            end
            ra = 16'(pa) * 16'(rb);
            run_op(ra, rb, 16'(pa), 8'd0, 1'b0, 1'b0, $sformatf("prod %0d*%0d", pa, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
